// File: rtl/pic_cpu_interface.sv
// Purpose: 8259 PIC bus master that runs the ICW1/ICW2/ICW4/OCW1 init sequence, issues non-specific EOI writes and fetches the vector over two INTA pulses.
// Latency: init takes 4*(WR_CYCLES+2) clks; an EOI write takes WR_CYCLES+2 clks; a vector appears 3+2*INTA_LOW_CYCLES+INTA_GAP_CYCLES clks after INT rises.
// Backpressure: vec_valid/vec_data hold until vec_ready; no new INTA sequence starts while a vector is held. Option macro: PIC_CPU_INTERFACE_AUTO_EOI_EN.
module pic_cpu_interface #(
  parameter int WR_CYCLES       = 2,
  parameter int INTA_LOW_CYCLES = 2,
  parameter int INTA_GAP_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       init_start,
  input  logic [7:0] icw1,
  input  logic [7:0] icw2,
  input  logic [7:0] icw4,
  input  logic [7:0] ocw1,
  output logic       init_busy,
  output logic       init_done,
  input  logic       INT,
  output logic       vec_valid,
  output logic [7:0] vec_data,
  input  logic       vec_ready,
  input  logic       eoi_req,
  output logic       chip_select,
  output logic       write_enable,
  output logic       INTA,
  output logic       A0,
  output logic [7:0] data_out,
  output logic       data_oe,
  input  logic [7:0] data_in
);

  // One counter times every multi-cycle phase; size it for the longest one.
  localparam int MAX_CYC_A = (WR_CYCLES > INTA_LOW_CYCLES) ? WR_CYCLES : INTA_LOW_CYCLES;
  localparam int MAX_CYC   = (MAX_CYC_A > INTA_GAP_CYCLES) ? MAX_CYC_A : INTA_GAP_CYCLES;
  localparam int CNT_W     = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);

  localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(WR_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOW_LAST = CNT_W'(INTA_LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(INTA_GAP_CYCLES - 1);

  // Non-specific EOI command byte (OCW2 with EOI bit set).
  localparam logic [7:0] EOI_BYTE = 8'h20;

  typedef enum logic [2:0] {
    IDLE,
    WR_SETUP,
    WR_STROBE,
    WR_HOLD,
    INTA1,
    GAP,
    INTA2,
    VEC_WAIT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CNT_W-1:0] cnt;

  // INT synchronizer
  logic int_meta;
  logic int_s;

  // Latched init bytes and the position within the current write burst
  logic [7:0] icw1_q;
  logic [7:0] icw2_q;
  logic [7:0] icw4_q;
  logic [7:0] ocw1_q;
  logic       wr_init;
  logic [1:0] wr_idx;

  // Selected byte/A0 for the write in flight
  logic [7:0] wr_byte;
  logic       wr_a0;

  // EOI bookkeeping and IDLE arbitration results
  logic eoi_pend;
  logic eoi_set;
  logic eoi_any;
  logic take_init;
  logic take_eoi;
  logic take_inta;
  logic last_init_hold;

`ifdef PIC_CPU_INTERFACE_AUTO_EOI_EN
  // The block queues its own EOI on every delivered vector; eoi_req has no effect.
  logic unused_eoi_req;
  assign unused_eoi_req = eoi_req;
  assign eoi_set        = (state == VEC_WAIT) && vec_ready;
  assign eoi_any        = eoi_pend;
`else
  // A request seen in IDLE is served straight away; elsewhere it is remembered.
  assign eoi_set = eoi_req;
  assign eoi_any = eoi_pend || eoi_req;
`endif

  // IDLE priority: init first, then a pending EOI, then the interrupt.
  assign take_init      = (state == IDLE) && init_start;
  assign take_eoi       = (state == IDLE) && !init_start && eoi_any;
  assign take_inta      = (state == IDLE) && !init_start && !eoi_any && int_s && !init_busy;
  assign last_init_hold = (state == WR_HOLD) && wr_init && (wr_idx == 2'd3);

  // Two-flop synchronizer for the asynchronous INT line
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      int_meta <= 1'b0;
      int_s    <= 1'b0;
    end else begin
      int_meta <= INT;
      int_s    <= int_meta;
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (take_init || take_eoi) begin
          state_nxt = WR_SETUP;
        end else if (take_inta) begin
          state_nxt = INTA1;
        end
      end
      WR_SETUP: state_nxt = WR_STROBE;
      WR_STROBE: begin
        if (cnt == WR_LAST) begin
          state_nxt = WR_HOLD;
        end
      end
      WR_HOLD: begin
        if (wr_init && (wr_idx != 2'd3)) begin
          state_nxt = WR_SETUP;
        end else begin
          state_nxt = IDLE;
        end
      end
      INTA1: begin
        if (cnt == LOW_LAST) begin
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_nxt = INTA2;
        end
      end
      INTA2: begin
        if (cnt == LOW_LAST) begin
          state_nxt = VEC_WAIT;
        end
      end
      VEC_WAIT: begin
        if (vec_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Phase timer restarts on every state change
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (state_nxt != state) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Init bytes are captured on the accepted init_start so later input changes are harmless
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      icw1_q <= 8'h00;
      icw2_q <= 8'h00;
      icw4_q <= 8'h00;
      ocw1_q <= 8'h00;
    end else if (take_init) begin
      icw1_q <= icw1;
      icw2_q <= icw2;
      icw4_q <= icw4;
      ocw1_q <= ocw1;
    end
  end

  // Burst bookkeeping: which kind of write is running and which byte of it
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_init <= 1'b0;
      wr_idx  <= 2'd0;
    end else if (take_init) begin
      wr_init <= 1'b1;
      wr_idx  <= 2'd0;
    end else if (take_eoi) begin
      wr_init <= 1'b0;
      wr_idx  <= 2'd0;
    end else if ((state == WR_HOLD) && wr_init && (wr_idx != 2'd3)) begin
      wr_idx <= wr_idx + 2'd1;
    end
  end

  // init_busy covers the cycle after acceptance through the init_done cycle
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      init_busy <= 1'b0;
    end else if (take_init) begin
      init_busy <= 1'b1;
    end else if (last_init_hold) begin
      init_busy <= 1'b0;
    end
  end

  // Pending EOI: repeated requests before service collapse into one flag
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      eoi_pend <= 1'b0;
    end else if (take_eoi) begin
      eoi_pend <= 1'b0;
    end else if (eoi_set) begin
      eoi_pend <= 1'b1;
    end
  end

  // Vector is sampled on the final low cycle of the second INTA pulse and held
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      vec_data <= 8'h00;
    end else if ((state == INTA2) && (cnt == LOW_LAST)) begin
      vec_data <= data_in;
    end
  end

  // Byte and A0 for the write in flight
  always_comb begin
    wr_byte = EOI_BYTE;
    wr_a0   = 1'b0;
    if (wr_init) begin
      case (wr_idx)
        2'd0: begin
          wr_byte = icw1_q;
          wr_a0   = 1'b0;
        end
        2'd1: begin
          wr_byte = icw2_q;
          wr_a0   = 1'b1;
        end
        2'd2: begin
          wr_byte = icw4_q;
          wr_a0   = 1'b1;
        end
        default: begin
          wr_byte = ocw1_q;
          wr_a0   = 1'b1;
        end
      endcase
    end
  end

  // Moore output decode; nothing here looks at vec_ready or other inputs
  always_comb begin
    chip_select  = 1'b1;
    write_enable = 1'b1;
    INTA         = 1'b1;
    A0           = 1'b0;
    data_out     = 8'h00;
    data_oe      = 1'b0;
    vec_valid    = 1'b0;
    init_done    = 1'b0;
    case (state)
      WR_SETUP, WR_STROBE, WR_HOLD: begin
        chip_select  = 1'b0;
        A0           = wr_a0;
        data_out     = wr_byte;
        data_oe      = 1'b1;
        write_enable = (state != WR_STROBE);
        init_done    = last_init_hold;
      end
      INTA1, INTA2: INTA = 1'b0;
      VEC_WAIT:     vec_valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pic_cpu_interface.sv
// Bench for pic_cpu_interface: randomized init bytes, vectors and EOI timing checked against a write-list / pulse-pattern model.
// Latency: follows the default parameters (2-clk strobe, 2 low / 2 gap INTA).
// Backpressure: vec_ready is withheld for varying lengths to prove the vector holds.
module tb_pic_cpu_interface;

  localparam int WR   = 2;
  localparam int LOW  = 2;
  localparam int GAPC = 2;
  localparam int WPER = WR + 2;
  // {cs, we, inta, a0, data_out, data_oe, vec_valid, vec_data, init_busy, init_done}
  localparam logic [23:0] RST_VAL = 24'hE0_0000;

  logic       clock = 1'b0;
  logic       reset_n, init_start, INT, vec_ready, eoi_req;
  logic [7:0] icw1, icw2, icw4, ocw1, data_in;
  logic       init_busy, init_done, vec_valid, chip_select, write_enable, INTA, A0, data_oe;
  logic [7:0] vec_data, data_out;

  int n_total = 0;
  int n_pass  = 0;

  pic_cpu_interface #(
    .WR_CYCLES(WR), .INTA_LOW_CYCLES(LOW), .INTA_GAP_CYCLES(GAPC)
  ) dut (
    .clock(clock), .reset_n(reset_n), .init_start(init_start),
    .icw1(icw1), .icw2(icw2), .icw4(icw4), .ocw1(ocw1),
    .init_busy(init_busy), .init_done(init_done), .INT(INT),
    .vec_valid(vec_valid), .vec_data(vec_data), .vec_ready(vec_ready),
    .eoi_req(eoi_req), .chip_select(chip_select), .write_enable(write_enable),
    .INTA(INTA), .A0(A0), .data_out(data_out), .data_oe(data_oe), .data_in(data_in)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       a0;
    logic [7:0] dat;
    logic [7:0] len;
  } wr_t;

  // Bus observer: completed writes, init_done pulses, INTA pulses, protocol violations
  wr_t        wr_q[$];
  int         we_run      = 0;
  logic       cur_a0      = 1'b0;
  logic [7:0] cur_dat     = 8'h00;
  int         done_cnt    = 0;
  int         inta_pulses = 0;
  int         bad_bus     = 0;
  int         pulse_no    = 0;
  int         low_run     = 0;
  logic       inta_prev   = 1'b1;
  logic [7:0] vector      = 8'h00;

  // Observes the bus and plays the 8259: the vector is on data_in only in the last low cycle of the second pulse
  always @(negedge clock) begin
    if (write_enable === 1'b0) begin
      we_run++;
      cur_a0  = A0;
      cur_dat = data_out;
    end else if (we_run > 0) begin
      wr_q.push_back('{cur_a0, cur_dat, 8'(we_run)});
      we_run = 0;
    end
    if (init_done === 1'b1) done_cnt++;
    if ((write_enable === 1'b0 && (chip_select !== 1'b0 || data_oe !== 1'b1)) ||
        (INTA === 1'b0 && (chip_select !== 1'b1 || data_oe !== 1'b0)))
      bad_bus++;
    if (INTA === 1'b0) begin
      if (inta_prev === 1'b1) begin
        pulse_no = (pulse_no == 2) ? 1 : pulse_no + 1;
        low_run  = 0;
        inta_pulses++;
      end
      low_run++;
    end
    inta_prev = INTA;
    if (INTA === 1'b0 && pulse_no == 2 && low_run == LOW) data_in = vector;
    else data_in = vector ^ 8'($urandom_range(1, 255));
    if (reset_n === 1'b0) pulse_no = 0;
  end

  function automatic logic [23:0] outs();
    return {chip_select, write_enable, INTA, A0, data_out, data_oe,
            vec_valid, vec_data, init_busy, init_done};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; init_start = 1'b0; INT = 1'b0; vec_ready = 1'b0; eoi_req = 1'b0;
    icw1 = 8'h00; icw2 = 8'h00; icw4 = 8'h00; ocw1 = 8'h00;
    tick(); tick();
    n_total++;
    if (outs() !== RST_VAL) $display("FAIL reset_hold got=%h want=%h", outs(), RST_VAL);
    else n_pass++;
    reset_n = 1'b1;
    tick(); tick();
    n_total++;
    if (outs() !== RST_VAL) $display("FAIL reset_release_idle got=%h want=%h", outs(), RST_VAL);
    else n_pass++;
  endtask

  task automatic test_init_fixed();
    logic [7:0]  b [4];
    logic [12:0] exp_v, got_v;
    int w, ph;
    b[0] = 8'h1F; b[1] = 8'hA8; b[2] = 8'h01; b[3] = 8'h00;
    done_cnt = 0;
    icw1 = b[0]; icw2 = b[1]; icw4 = b[2]; ocw1 = b[3];
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    for (int c = 1; c <= 4 * WPER + 1; c++) begin
      if (c <= 4 * WPER) begin
        w  = (c - 1) / WPER;
        ph = (c - 1) % WPER;
        exp_v = {1'b0, !(ph >= 1 && ph <= WR), (w != 0), b[w], 1'b1, 1'b1, (c == 4 * WPER)};
      end else begin
        exp_v = {1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      end
      got_v = {chip_select, write_enable, A0, data_out, data_oe, init_busy, init_done};
      n_total++;
      if (got_v !== exp_v) $display("FAIL init_fixed_cycle%0d got=%h want=%h", c, got_v, exp_v);
      else n_pass++;
      tick();
    end
    n_total++;
    if (done_cnt !== 1) $display("FAIL init_fixed_done_pulses got=%0d want=1", done_cnt);
    else n_pass++;
  endtask

  task automatic test_init_random();
    logic [7:0] b [4];
    wr_t        exp_q[$];
    wr_t        got;
    int         k;
    bit         do_eoi;
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
      do_eoi = (it % 2 == 1);
      exp_q.delete();
      for (int i = 0; i < 4; i++) exp_q.push_back('{(i != 0), b[i], 8'(WR)});
`ifndef PIC_CPU_INTERFACE_AUTO_EOI_EN
      if (do_eoi) exp_q.push_back('{1'b0, 8'h20, 8'(WR)});
`endif
      wr_q.delete();
      done_cnt = 0;
      icw1 = b[0]; icw2 = b[1]; icw4 = b[2]; ocw1 = b[3];
      init_start = 1'b1;
      tick();
      init_start = 1'b0;
      n_total++;
      if (init_busy !== 1'b1) $display("FAIL init_rand_busy_rise got=%b want=1", init_busy);
      else n_pass++;
      k = $urandom_range(2, 4 * WPER - 2);
      repeat (k - 1) tick();
      // A second init_start mid-sequence must be ignored; an eoi_req here is held for later
      icw1 = ~b[0]; icw2 = ~b[1]; icw4 = ~b[2]; ocw1 = ~b[3];
      init_start = 1'b1;
      eoi_req    = do_eoi;
      tick();
      init_start = 1'b0;
      eoi_req    = 1'b0;
      repeat (5 * WPER + 4) tick();
      n_total++;
      if (wr_q.size() != exp_q.size())
        $display("FAIL init_rand_write_count it=%0d got=%0d want=%0d", it, wr_q.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < exp_q.size(); i++) begin
        got = (i < wr_q.size()) ? wr_q[i] : '0;
        n_total++;
        if (got !== exp_q[i]) $display("FAIL init_rand_write%0d it=%0d got=%h want=%h", i, it, got, exp_q[i]);
        else n_pass++;
      end
      n_total++;
      if (done_cnt !== 1) $display("FAIL init_rand_done_pulses it=%0d got=%0d want=1", it, done_cnt);
      else n_pass++;
    end
  endtask

  task automatic test_vector();
    int         t, hold, p0;
    logic [7:0] v;
    logic [3:0] exp_v, got_v;
    for (int it = 0; it < 4; it++) begin
      v = (it == 0) ? 8'hA9 : 8'($urandom);
      vector = v;
      wr_q.delete();
      INT = 1'b1;
      t = 0;
      while (INTA !== 1'b0 && t < 10) begin tick(); t++; end
      n_total++;
      if (INTA !== 1'b0) $display("FAIL vec_inta_start it=%0d got=%b want=0", it, INTA);
      else n_pass++;
      for (int c = 0; c < 2 * LOW + GAPC; c++) begin
        // INT falling part-way through must not cut the acknowledge short
        if ((it == 1 && c == LOW) || (it == 2 && c == 0) || (it == 3 && c == 2 * LOW + GAPC - 1)) INT = 1'b0;
        exp_v = {(c >= LOW && c < LOW + GAPC), 1'b1, 1'b0, 1'b0};
        got_v = {INTA, chip_select, data_oe, vec_valid};
        n_total++;
        if (got_v !== exp_v) $display("FAIL vec_inta_pattern it=%0d c=%0d got=%b want=%b", it, c, got_v, exp_v);
        else n_pass++;
        tick();
      end
      INT  = 1'b0;
      hold = (it == 0) ? 5 : $urandom_range(1, 6);
      for (int h = 0; h < hold; h++) begin
        n_total++;
        if ({vec_valid, vec_data} !== {1'b1, v})
          $display("FAIL vec_hold it=%0d h=%0d got=%b/%h want=1/%h", it, h, vec_valid, vec_data, v);
        else n_pass++;
        tick();
      end
      vec_ready = 1'b1;
      #1;
      n_total++;
      if (vec_valid !== 1'b1) $display("FAIL vec_valid_during_ready it=%0d got=%b want=1", it, vec_valid);
      else n_pass++;
      tick();
      vec_ready = 1'b0;
      n_total++;
      if (vec_valid !== 1'b0) $display("FAIL vec_valid_after_ready it=%0d got=%b want=0", it, vec_valid);
      else n_pass++;
      p0 = inta_pulses;
      repeat (2 * WPER) tick();
      n_total++;
      if (inta_pulses !== p0) $display("FAIL vec_no_retrigger it=%0d got=%0d want=%0d", it, inta_pulses, p0);
      else n_pass++;
`ifdef PIC_CPU_INTERFACE_AUTO_EOI_EN
      n_total++;
      if (wr_q.size() != 1 || wr_q[0] !== wr_t'{1'b0, 8'h20, 8'(WR)})
        $display("FAIL vec_auto_eoi it=%0d got_count=%0d want=1 write 20/A0=0", it, wr_q.size());
      else n_pass++;
`else
      n_total++;
      if (wr_q.size() != 0) $display("FAIL vec_no_write it=%0d got=%0d want=0", it, wr_q.size());
      else n_pass++;
`endif
    end
  endtask

  task automatic test_eoi_pending();
    int t;
    wr_t exp_w;
    exp_w  = '{1'b0, 8'h20, 8'(WR)};
    vector = 8'($urandom);
    wr_q.delete();
    INT = 1'b1;
    t = 0;
    while (vec_valid !== 1'b1 && t < 20) begin tick(); t++; end
    INT = 1'b0;
    n_total++;
    if (vec_valid !== 1'b1 || vec_data !== vector)
      $display("FAIL eoi_pend_vector got=%b/%h want=1/%h", vec_valid, vec_data, vector);
    else n_pass++;
    eoi_req = 1'b1; tick(); eoi_req = 1'b0; tick();
    eoi_req = 1'b1; tick(); eoi_req = 1'b0; tick();
    n_total++;
    if (wr_q.size() != 0 || chip_select !== 1'b1 || vec_valid !== 1'b1)
      $display("FAIL eoi_pend_waits got_writes=%0d cs=%b vv=%b want=0/1/1", wr_q.size(), chip_select, vec_valid);
    else n_pass++;
    vec_ready = 1'b1;
    tick();
    vec_ready = 1'b0;
    repeat (3 * WPER) tick();
    n_total++;
    if (wr_q.size() != 1) $display("FAIL eoi_pend_count got=%0d want=1", wr_q.size());
    else n_pass++;
    n_total++;
    if (wr_q.size() == 0 || wr_q[0] !== exp_w)
      $display("FAIL eoi_pend_write got=%h want=%h", (wr_q.size() > 0) ? wr_q[0] : wr_t'('0), exp_w);
    else n_pass++;
  endtask

  task automatic test_eoi_idle();
    wr_q.delete();
    eoi_req = 1'b1;
    tick();
    eoi_req = 1'b0;
    repeat (2 * WPER) tick();
`ifdef PIC_CPU_INTERFACE_AUTO_EOI_EN
    n_total++;
    if (wr_q.size() != 0) $display("FAIL eoi_idle_ignored got=%0d want=0", wr_q.size());
    else n_pass++;
`else
    n_total++;
    if (wr_q.size() != 1 || wr_q[0] !== wr_t'{1'b0, 8'h20, 8'(WR)})
      $display("FAIL eoi_idle_write got_count=%0d want=1 write 20/A0=0", wr_q.size());
    else n_pass++;
`endif
  endtask

  task automatic test_init_and_int();
    int t, p0;
    vector = 8'($urandom);
    wr_q.delete();
    p0 = inta_pulses;
    icw1 = 8'($urandom); icw2 = 8'($urandom); icw4 = 8'($urandom); ocw1 = 8'($urandom);
    INT = 1'b1;
    tick(); tick();
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    n_total++;
    if ({chip_select, INTA} !== 2'b01) $display("FAIL both_init_wins got=%b want=01", {chip_select, INTA});
    else n_pass++;
    t = 0;
    while (init_done !== 1'b1 && t < 40) begin tick(); t++; end
    n_total++;
    if (init_done !== 1'b1 || inta_pulses !== p0)
      $display("FAIL both_init_first done=%b pulses=%0d want=1/%0d", init_done, inta_pulses, p0);
    else n_pass++;
    t = 0;
    while (vec_valid !== 1'b1 && t < 40) begin tick(); t++; end
    INT = 1'b0;
    n_total++;
    if (vec_valid !== 1'b1 || vec_data !== vector || inta_pulses !== p0 + 2 || wr_q.size() != 4)
      $display("FAIL both_then_vector got=%b/%h pulses=%0d writes=%0d want=1/%h %0d 4",
               vec_valid, vec_data, inta_pulses - p0, wr_q.size(), vector, 2);
    else n_pass++;
    repeat (3) tick();
    vec_ready = 1'b1;
    tick();
    vec_ready = 1'b0;
    repeat (2 * WPER + 2) tick();
  endtask

  task automatic test_reset_mid();
    int t;
    bit seen;
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    tick();
    n_total++;
    if (write_enable !== 1'b0) $display("FAIL rst_wr_strobe_reached got=%b want=0", write_enable);
    else n_pass++;
    reset_n = 1'b0;
    tick();
    n_total++;
    if (outs() !== RST_VAL) $display("FAIL rst_mid_write got=%h want=%h", outs(), RST_VAL);
    else n_pass++;
    reset_n = 1'b1;
    tick();
    n_total++;
    if (outs() !== RST_VAL) $display("FAIL rst_mid_write_after got=%h want=%h", outs(), RST_VAL);
    else n_pass++;
    vector = 8'($urandom);
    INT = 1'b1;
    t = 0;
    while (INTA !== 1'b0 && t < 10) begin tick(); t++; end
    repeat (LOW + GAPC) tick();
    n_total++;
    if (INTA !== 1'b0) $display("FAIL rst_inta2_reached got=%b want=0", INTA);
    else n_pass++;
    reset_n = 1'b0;
    INT     = 1'b0;
    tick();
    n_total++;
    if (outs() !== RST_VAL) $display("FAIL rst_mid_inta got=%h want=%h", outs(), RST_VAL);
    else n_pass++;
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      tick();
      if (vec_valid !== 1'b0 || INTA !== 1'b1) seen = 1'b1;
    end
    n_total++;
    if (seen) $display("FAIL rst_mid_inta_quiet got=activity want=none");
    else n_pass++;
  endtask

  task automatic test_bus_protocol();
    n_total++;
    if (bad_bus !== 0) $display("FAIL bus_protocol got=%0d bad cycles want=0", bad_bus);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_init_fixed();
    test_init_random();
    test_vector();
    test_eoi_pending();
    test_eoi_idle();
    test_init_and_int();
    test_reset_mid();
    test_bus_protocol();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pic_cpu_interface.md
PIC_CPU_INTERFACE -- requirements
Module: pic_cpu_interface

Interface
REQ-001 SHALL have parameter WR_CYCLES, default 2, write_enable low-time in clocks (>=1).
REQ-002 SHALL have parameter INTA_LOW_CYCLES, default 2, low-time of each INTA pulse in clocks (>=1).
REQ-003 SHALL have parameter INTA_GAP_CYCLES, default 2, INTA high-time between the two pulses (>=1).
REQ-004 SHALL have ports: clock  in  1  sole clock, rising edge.
REQ-005 SHALL have: reset_n  in  1  synchronous, active-low reset.
REQ-006 SHALL have: init_start  in  1  pulse, begins ICW1/ICW2/ICW4/OCW1 sequence.
REQ-007 SHALL have: icw1, icw2, icw4, ocw1  in  8 each  init bytes, sampled on the accepted init_start cycle.
REQ-008 SHALL have: init_busy  out  1  init sequence in progress; init_done  out  1  one-cycle pulse at end of init.
REQ-009 SHALL have: INT  in  1  interrupt request from the 8259, asynchronous.
REQ-010 SHALL have: vec_valid  out  1; vec_data  out  8; vec_ready  in  1  vector handshake to CPU core.
REQ-011 SHALL have: eoi_req  in  1  pulse, request non-specific EOI.
REQ-012 SHALL have: chip_select, write_enable, INTA  out  1 each, active-low; A0  out  1; data_out  out  8; data_oe  out  1; data_in  in  8.

Function
REQ-013 INT SHALL pass a 2-flop synchronizer; only the synchronized level (int_s) is used.
REQ-014 FSM states SHALL be IDLE, WR_SETUP, WR_STROBE, WR_HOLD, INTA1, GAP, INTA2, VEC_WAIT.
REQ-015 IDLE arbitration, highest first: init_start, pending EOI, int_s high.
REQ-016 Bus write: WR_SETUP 1 clk (chip_select=0, A0, data_out, data_oe=1); WR_STROBE WR_CYCLES clks (write_enable=0); WR_HOLD 1 clk (write_enable=1, chip_select=0); then IDLE or next write.
REQ-017 Init SHALL issue back-to-back writes: icw1 A0=0, icw2 A0=1, icw4 A0=1, ocw1 A0=1; init_busy high from the cycle after init_start until init_done.
REQ-018 EOI SHALL be one write of 0x20 with A0=0.
REQ-019 eoi_req arriving in any non-IDLE state SHALL set a pending flag; multiple requests before service collapse to one.
REQ-020 init_start outside IDLE SHALL be ignored; INT SHALL be ignored while init_busy.
REQ-021 Ack: INTA1 INTA=0 for INTA_LOW_CYCLES; GAP INTA=1 for INTA_GAP_CYCLES; INTA2 INTA=0 for INTA_LOW_CYCLES; chip_select stays 1, data_oe=0.
REQ-022 vec_data SHALL capture data_in on the last INTA2 cycle and hold stable until handshake completes.
REQ-023 VEC_WAIT: vec_valid=1 until the cycle vec_ready=1, then IDLE; vec_valid SHALL NOT depend combinationally on vec_ready.
REQ-024 int_s falling during INTA1/GAP/INTA2 SHALL NOT abort the sequence; the captured byte is delivered as-is.
REQ-025 New INTA sequence SHALL NOT start while vec_valid=1.

Reset
REQ-026 reset_n=0 at a rising edge SHALL force IDLE, from any state, including mid-write or mid-INTA.
REQ-027 Reset values: chip_select=1, write_enable=1, INTA=1, A0=0, data_out=0x00, data_oe=0, vec_valid=0, vec_data=0x00, init_busy=0, init_done=0; synchronizer and pending flag cleared.

Configuration
REQ-028 Macro PIC_CPU_INTERFACE_AUTO_EOI_EN: defined -> after each vec_ready handshake the block sets the EOI pending flag itself and eoi_req is ignored; undefined -> EOI issued only on eoi_req.

Verification
REQ-029 init_start with icw1=0x1F, icw2=0xA8, icw4=0x01, ocw1=0x00 -> four writes (A0 0,1,1,1), each write_enable low exactly 2 clks, init_done one pulse, 4x4=16 clks after init_start.
REQ-030 INT high, data_in=0xA9 during INTA2 -> two INTA pulses 2 low/2 high/2 low, vec_valid=1 with vec_data=0xA9; vec_ready held 0 for 5 clks keeps vector stable.
REQ-031 eoi_req during VEC_WAIT, twice -> exactly one write 0x20 A0=0 after handshake.
REQ-032 init_start and INT same IDLE cycle -> init completes first, then INTA sequence.
REQ-033 reset_n low during WR_STROBE and during INTA2 -> next clock all outputs at reset values, no vec_valid.
REQ-034 With PIC_CPU_INTERFACE_AUTO_EOI_EN, vector handshake -> 0x20 write follows with no eoi_req.
